prog_loader: RTL and testbench

- Write-side counterpart of the instruction fetch unit: receives a program image as a byte stream from the UART receiver and writes 32-bit instruction words into the program ROM block RAM.
- Holds the CPU (fetch unit) in reset while loading, and releases it only after a verified image.
- The top level muxes the prgrom port between this block (cpu_hold=1) and the fetch unit (cpu_hold=0).

---
 rtl/prog_loader.sv | 177 +++++++++++++++++
 tb/tb_prog_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program image loader: parses a framed UART byte stream and writes 32-bit words
// into program ROM, holding the CPU in reset until a checksum-verified image is in place.
module prog_loader #(
   parameter int ADDR_WIDTH     = 14,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [ADDR_WIDTH:0]   words_written,
   output logic [2:0]            dbg_state
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR    = 3'd1,
      S_CNT_HI = 3'd2,
      S_CNT_LO = 3'd3,
      S_DATA   = 3'd4,
      S_CHK    = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [15:0]           r_count;
   logic [23:0]           r_asm;
   logic [1:0]            r_bidx;
   logic [7:0]            r_chk;
   logic [TW-1:0]         r_tmo;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [ADDR_WIDTH:0]   r_words;
   logic [1:0]            r_err_code;

   logic                  w_start_acc;
   logic                  w_timed;
   logic                  w_timeout;
   logic [15:0]           w_count_full;
   logic                  w_word_done;
   logic                  w_last_word;
   logic                  w_set_err;
   logic [1:0]            w_err_code;

   assign w_start_acc  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
   assign w_timed      = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                         (r_state == S_DATA)   || (r_state == S_CHK);
   assign w_timeout    = w_timed && !byte_valid && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
   assign w_count_full = {r_count[15:8], byte_data};
   assign w_word_done  = byte_valid && (r_state == S_DATA) && (r_bidx == 2'd3);
   // r_words still holds the pre-increment count while the 4th byte arrives
   assign w_last_word  = (32'(r_words) + 32'd1) == 32'(r_count);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_set_err  = 1'b0;
      w_err_code = 2'd0;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) w_next = S_HDR;
         end
         S_HDR: begin
            if (byte_valid && byte_data == 8'hA5) w_next = S_CNT_HI;
         end
         S_CNT_HI: begin
            if (byte_valid) w_next = S_CNT_LO;
         end
         S_CNT_LO: begin
            if (byte_valid) begin
               if (32'(w_count_full) > (32'd1 << ADDR_WIDTH)) begin
                  w_next     = S_ERR;
                  w_set_err  = 1'b1;
                  w_err_code = 2'd1;
               end else if (w_count_full == 16'd0) begin
                  w_next = S_CHK;
               end else begin
                  w_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (w_word_done && w_last_word) w_next = S_CHK;
         end
         S_CHK: begin
            if (byte_valid) begin
               if (byte_data == r_chk) begin
                  w_next = S_DONE;
               end else begin
                  w_next     = S_ERR;
                  w_set_err  = 1'b1;
                  w_err_code = 2'd3;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (w_timeout) begin
         w_next     = S_ERR;
         w_set_err  = 1'b1;
         w_err_code = 2'd2;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count    <= '0;
         r_asm      <= '0;
         r_bidx     <= '0;
         r_chk      <= '0;
         r_tmo      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_words    <= '0;
         r_err_code <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_start_acc) begin
            r_count    <= '0;
            r_bidx     <= '0;
            r_chk      <= '0;
            r_tmo      <= '0;
            r_words    <= '0;
            r_err_code <= '0;
         end else begin
            if (w_timed) r_tmo <= byte_valid ? '0 : r_tmo + TW'(1);
            if (w_set_err) r_err_code <= w_err_code;
            if (byte_valid && r_state == S_CNT_HI) r_count[15:8] <= byte_data;
            if (byte_valid && r_state == S_CNT_LO) r_count[7:0]  <= byte_data;
            if (byte_valid && r_state == S_DATA) begin
               r_chk  <= r_chk ^ byte_data;
               r_bidx <= r_bidx + 2'd1;
               r_asm  <= {r_asm[15:0], byte_data};
               if (r_bidx == 2'd3) begin
                  r_we    <= 1'b1;
                  r_addr  <= r_words[ADDR_WIDTH-1:0];
                  r_wdata <= {r_asm, byte_data};
                  r_words <= r_words + {{ADDR_WIDTH{1'b0}}, 1'b1};
               end
            end
         end
      end
   end

   assign mem_we        = r_we;
   assign mem_addr      = r_addr;
   assign mem_wdata     = r_wdata;
   assign busy          = (r_state == S_HDR)  || (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                          (r_state == S_DATA) || (r_state == S_CHK);
   // ERR keeps the CPU parked so a partial image never runs
   assign cpu_hold      = busy || (r_state == S_ERR);
   assign done          = (r_state == S_DONE);
   assign error         = (r_state == S_ERR);
   assign err_code      = r_err_code;
   assign words_written = r_words;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are driven byte by byte, expected ROM writes
// go into a queue that a negedge monitor drains, and status is checked after each frame.
module tb_prog_loader;

   localparam int AW  = 4;
   localparam int TMO = 50;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = 8'h00;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          busy;
   logic          done;
   logic          error;
   logic [1:0]    err_code;
   logic [AW:0]   words_written;
   logic [2:0]    dbg_state;

   logic [AW+31:0] exp_q[$];
   int n_cmp = 0;
   int n_mis = 0;

   prog_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
      .err_code(err_code), .words_written(words_written), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard monitor
   always @(negedge clock) begin
      if (mem_we) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL unexpected_write: got addr=%0h data=%08h, expected no write", mem_addr, mem_wdata);
         end else begin
            logic [AW+31:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               n_mis++;
               $display("FAIL rom_write: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                        mem_addr, mem_wdata, e[AW+31:32], e[31:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // driver tasks: all called at posedge+1
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      tick(1);
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic check_status(input string tag, input logic e_done, input logic e_err,
                               input logic [1:0] e_code, input logic e_hold, input int e_ww);
      tick(2);
      check({tag, "_done"},     32'(done),          32'(e_done));
      check({tag, "_error"},    32'(error),         32'(e_err));
      check({tag, "_err_code"}, 32'(err_code),      32'(e_code));
      check({tag, "_cpu_hold"}, 32'(cpu_hold),      32'(e_hold));
      check({tag, "_busy"},     32'(busy),          32'd0);
      check({tag, "_words"},    32'(words_written), 32'(e_ww));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_we"},   32'(mem_we),        32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr),      32'd0);
      check({tag, "_wdata"},    mem_wdata,          32'd0);
      check({tag, "_cpu_hold"}, 32'(cpu_hold),      32'd0);
      check({tag, "_busy"},     32'(busy),          32'd0);
      check({tag, "_done"},     32'(done),          32'd0);
      check({tag, "_error"},    32'(error),         32'd0);
      check({tag, "_err_code"}, 32'(err_code),      32'd0);
      check({tag, "_words"},    32'(words_written), 32'd0);
      check({tag, "_state"},    32'(dbg_state),     32'd0);
   endtask

   initial begin
      logic [7:0] f1 [12];
      logic [7:0] f2 [8];
      f1 = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h29};
      f2 = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE};

      #12;
      check_all_zero("reset");
      reset = 1'b0;
      tick(2);

      // two-word frame
      expect_write(4'd0, 32'h24080005);
      expect_write(4'd1, 32'h00000000);
      pulse_start();
      foreach (f1[i]) send_byte(f1[i]);
      check_status("two_words", 1'b1, 1'b0, 2'd0, 1'b0, 2);

      // start with a simultaneous byte: that A5 must be dropped; then a COUNT=0 frame
      start = 1'b1; byte_valid = 1'b1; byte_data = 8'hA5;
      tick(1);
      start = 1'b0; byte_valid = 1'b0;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check_status("count_zero", 1'b1, 1'b0, 2'd0, 1'b0, 0);

      // leading junk, start mid-frame ignored, good checksum
      expect_write(4'd0, 32'hDEADBEEF);
      pulse_start();
      foreach (f2[i]) begin
         send_byte(f2[i]);
         if (i == 6) pulse_start();
      end
      send_byte(8'hEF); send_byte(8'h22);
      check_status("junk_hdr", 1'b1, 1'b0, 2'd0, 1'b0, 1);

      // same frame, bad checksum
      expect_write(4'd0, 32'hDEADBEEF);
      pulse_start();
      foreach (f2[i]) send_byte(f2[i]);
      send_byte(8'hEF); send_byte(8'h23);
      check_status("bad_chk", 1'b0, 1'b1, 2'd3, 1'b1, 1);

      // size overflow: 17 words > 2^4
      pulse_start();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h11);
      check_status("overflow", 1'b0, 1'b1, 2'd1, 1'b1, 0);

      // exactly 2^4 words fill the ROM; each word is four copies of its index, checksum 0
      pulse_start();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
      for (int w = 0; w < 16; w++) begin
         expect_write(AW'(w), {4{8'(w)}});
         repeat (4) send_byte(8'(w));
      end
      send_byte(8'h00);
      check_status("full_rom", 1'b1, 1'b0, 2'd0, 1'b0, 16);

      // timeout after the count bytes and one data byte
      pulse_start();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
      tick(TMO - 1);
      check("tmo_not_yet_busy",  32'(busy),  32'd1);
      check("tmo_not_yet_error", 32'(error), 32'd0);
      tick(1);
      check("tmo_error",    32'(error),    32'd1);
      check("tmo_err_code", 32'(err_code), 32'd2);
      check("tmo_busy",     32'(busy),     32'd0);
      check("tmo_cpu_hold", 32'(cpu_hold), 32'd1);

      // asynchronous reset during DATA after two words
      expect_write(4'd0, 32'h11223344);
      expect_write(4'd1, 32'h55667788);
      pulse_start();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
      send_byte(8'hAA); send_byte(8'hBB);
      #2 reset = 1'b1;
      #1;
      check_all_zero("mid_reset");
      @(posedge clock);
      #1 reset = 1'b0;
      tick(1);

      // reload after reset
      expect_write(4'd0, 32'h01020304);
      pulse_start();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h04);
      check_status("reload", 1'b1, 1'b0, 2'd0, 1'b0, 1);

      tick(3);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
